// File: rtl/sm_divider.sv
// Sign-magnitude 8-bit divider: 7-iteration restoring division on the magnitudes,
// quotient then remainder delivered on obus over two consecutive cycles.
module sm_divider (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       bgn,
  input  logic [7:0] ibus,
  output logic       fin,
  output logic [7:0] obus,
  output logic       busy,
  output logic       dbz
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_Y = 3'd1,
    DIV    = 3'd2,
    OUT_Q  = 3'd3,
    OUT_R  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [6:0]  a_q, a_d;
  logic [6:0]  b_q, b_d;
  logic [6:0]  quo_q, quo_d;
  logic [6:0]  rem_q, rem_d;
  logic        dz_q, dz_d;
  logic        fin_q, fin_d;
  logic        busy_q, busy_d;
  logic        dbz_q, dbz_d;
  logic [7:0]  obus_q, obus_d;

  logic [7:0]  trial;
  logic [6:0]  diff;
  logic        ge;
  logic [6:0]  q_mag, r_mag;

  // quo_q doubles as the dividend shift register: its MSB feeds the next bit
  assign trial = {rem_q, quo_q[6]};
  assign ge    = (trial >= {1'b0, b_q});
  assign diff  = trial[6:0] - b_q;
  assign q_mag = dz_q ? 7'h7F : quo_q;
  assign r_mag = dz_q ? a_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    fin_d   = fin_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    obus_d  = obus_q;
    unique case (state_q)
      IDLE: begin
        if (bgn) begin
          sa_d    = ibus[7];
          a_d     = ibus[6:0];
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          state_d = LOAD_Y;
        end
      end
      LOAD_Y: begin
        sb_d    = ibus[7];
        b_d     = ibus[6:0];
        dz_d    = (ibus[6:0] == 7'd0);
        quo_d   = a_q;
        rem_d   = 7'd0;
        cnt_d   = 3'd0;
        state_d = DIV;
      end
      DIV: begin
        rem_d = ge ? diff : trial[6:0];
        quo_d = {quo_q[5:0], ge};
        if (cnt_q == 3'd6) begin
          cnt_d   = 3'd0;
          state_d = OUT_Q;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      OUT_Q: begin
        obus_d  = {(sa_q ^ sb_q) & (q_mag != 7'd0), q_mag};
        fin_d   = 1'b1;
        dbz_d   = dz_q;
        state_d = OUT_R;
      end
      OUT_R: begin
        // counter is idle here, so it marks whether the remainder was sent
        if (cnt_q == 3'd0) begin
          obus_d = {sa_q & (r_mag != 7'd0), r_mag};
          cnt_d  = 3'd1;
        end else begin
          fin_d   = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= 7'd0;
      b_q     <= 7'd0;
      quo_q   <= 7'd0;
      rem_q   <= 7'd0;
      dz_q    <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
      obus_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
      obus_q  <= obus_d;
    end
  end

  assign fin  = fin_q;
  assign obus = obus_q;
  assign busy = busy_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_sm_divider.sv
// Scenario bench for sm_divider: expected words are queued at operand launch
// and popped when the quotient/remainder appear on obus.
module tb_sm_divider;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       bgn;
  logic [7:0] ibus;
  logic       fin;
  logic [7:0] obus;
  logic       busy;
  logic       dbz;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  sm_divider dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bgn   (bgn),
    .ibus  (ibus),
    .fin   (fin),
    .obus  (obus),
    .busy  (busy),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ma, mb, qm, rm;
    ma = int'(x[6:0]);
    mb = int'(y[6:0]);
    if (mb == 0) begin
      qm = 127; rm = ma; e.dz = 1'b1;
    end else begin
      qm = ma / mb; rm = ma % mb; e.dz = 1'b0;
    end
    e.q = {(x[7] ^ y[7]) && (qm != 0), 7'(qm)};
    e.r = {x[7] && (rm != 0), 7'(rm)};
    return e;
  endfunction

  // One full operation: E0 dividend, E1 divisor, then observe after E1..E11.
  // pulse_edge > 1 raises bgn so that it is sampled at that edge.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int pulse_edge);
    exp_t e;
    exp_t got_e;
    exp_q.push_back(model(x, y));
    @(negedge clk); bgn = 1'b1; ibus = x;
    @(posedge clk);
    @(negedge clk); bgn = 1'b0; ibus = y;
    total++;
    if (busy !== 1'b1 || dbz !== 1'b0 || fin !== 1'b0) begin
      bad++;
      $display("FAIL e0_accept x=%h y=%h busy=%b dbz=%b fin=%b want busy=1 dbz=0 fin=0", x, y, busy, dbz, fin);
    end
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        total++;
        if (fin !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL early_fin x=%h y=%h edge=E%0d fin=%b busy=%b want fin=0 busy=1", x, y, k, fin, busy);
        end
      end else if (k == 9) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_empty x=%h y=%h got=0 want=1 entries", x, y);
          e = model(x, y);
        end else begin
          e = exp_q.pop_front();
        end
        got_e.q = obus;
        total++;
        if (fin !== 1'b1 || obus !== e.q || dbz !== e.dz) begin
          bad++;
          $display("FAIL quotient x=%h y=%h obus=%h fin=%b dbz=%b want obus=%h fin=1 dbz=%b",
                   x, y, obus, fin, dbz, e.q, e.dz);
        end
      end else if (k == 10) begin
        total++;
        if (fin !== 1'b1 || obus !== e.r) begin
          bad++;
          $display("FAIL remainder x=%h y=%h obus=%h fin=%b want obus=%h fin=1", x, y, obus, fin, e.r);
        end
      end else begin
        total++;
        if (fin !== 1'b0 || busy !== 1'b0 || obus !== e.r || dbz !== e.dz) begin
          bad++;
          $display("FAIL done x=%h y=%h fin=%b busy=%b obus=%h dbz=%b want fin=0 busy=0 obus=%h dbz=%b",
                   x, y, fin, busy, obus, dbz, e.r, e.dz);
        end
        $display("op x=%h y=%h q=%h r=%h dbz=%b", x, y, got_e.q, obus, dbz);
      end
      if (k < 11) begin
        bgn  = (k + 1 == pulse_edge);
        ibus = 8'($urandom);
        @(posedge clk);
      end else begin
        bgn = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; bgn = 1'b0; ibus = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (fin !== 1'b0 || busy !== 1'b0 || dbz !== 1'b0 || obus !== 8'h00) begin
      bad++;
      $display("FAIL reset fin=%b busy=%b dbz=%b obus=%h want 0 0 0 00", fin, busy, dbz, obus);
    end
    $display("reset fin=%b busy=%b dbz=%b obus=%h", fin, busy, dbz, obus);
    rst_b = 1'b1;
  endtask

  task automatic test_directed();
    do_op(8'b10010111, 8'b00000011, 0);
    do_op(8'b01100100, 8'b10000111, 0);
    do_op(8'b10000010, 8'b00000011, 0);
  endtask

  task automatic test_dbz();
    do_op(8'b00000101, 8'b10000000, 0);
    do_op(8'b10000000, 8'b00000000, 0);
    do_op(8'b00001001, 8'b00000010, 0); // dbz checked clear after E0 inside do_op
  endtask

  task automatic test_bgn_ignored();
    do_op(8'b10010111, 8'b00000011, 4);
    do_op(8'b00110011, 8'b00000101, 11);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || fin !== 1'b0) begin
      bad++;
      $display("FAIL e11_bgn busy=%b fin=%b want busy=0 fin=0", busy, fin);
    end
    $display("e11 bgn check busy=%b", busy);
  endtask

  task automatic test_back_to_back();
    do_op(8'b01111111, 8'b00000001, 0);
    do_op(8'b11111111, 8'b01111111, 0);
    do_op(8'b00000011, 8'b00000111, 0);
  endtask

  task automatic test_reset_abort();
    int fin_seen;
    fin_seen = 0;
    @(negedge clk); bgn = 1'b1; ibus = 8'b00101010;
    @(posedge clk);
    @(negedge clk); bgn = 1'b0; ibus = 8'b00000100;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_b = 1'b1;
    total++;
    if (busy !== 1'b0 || obus !== 8'h00 || dbz !== 1'b0) begin
      bad++;
      $display("FAIL abort_state busy=%b obus=%h dbz=%b want 0 00 0", busy, obus, dbz);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fin === 1'b1) fin_seen++;
    end
    total++;
    if (fin_seen != 0) begin
      bad++;
      $display("FAIL abort_no_fin fin_cycles=%0d want 0", fin_seen);
    end
    $display("abort fin_cycles=%0d", fin_seen);
    do_op(8'b10010111, 8'b10000011, 0);
  endtask

  task automatic test_random();
    logic [7:0] x, y;
    for (int i = 0; i < 8; i++) begin
      x = 8'($urandom);
      y = (i == 3) ? {1'($urandom), 7'd0} : 8'($urandom);
      do_op(x, y, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_dbz();
    test_bgn_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover entries=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t want finish before 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
